// File: rtl/service_gate_sequencer.sv
// service_gate_sequencer
// Runs one PHASES-cycle time pulse per accepted TP_START and issues the
// per-register read, clear and write gates plus the CI carry-in for it.
// Request sets are latched once at acceptance; every output is a flop
// with asynchronous active-low reset, so gates are glitch-free and drop
// immediately when SIM_RST_n falls.
// Optional build macro: SVC_GATE_CONFLICT_EN enables the sticky
// read-conflict flag RD_CONF; without it RD_CONF is tied to 0.
//
//   state | meaning
//   IDLE  | no pulse in progress, waiting for TP_START
//   RUN   | pulse in progress, ph counts 0..PHASES-1
module service_gate_sequencer #(
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int PHASES = 4,
    parameter int RT_PH  = 1,
    parameter int CT_PH  = 2,
    parameter int WT_PH  = 3,
    parameter int G_IDX  = 5
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST_n,
    input  logic              TP_START,
    input  logic [NREG-1:0]   RD_REQ,
    input  logic [NREG-1:0]   WR_REQ,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              ADDR_RD,
    input  logic              ADDR_WR,
    input  logic              CI_REQ,
    input  logic              GINH,
    output logic [NREG-1:0]   RDG,
    output logic [NREG-1:0]   CLRG,
    output logic [NREG-1:0]   WRG,
    output logic              CI01,
    output logic              BUSY,
    output logic              DONE,
    output logic              RD_CONF
);

    localparam int PH_W = $clog2(PHASES);

    function automatic logic [PHASES-1:0] phase_mask(input int lo, input int hi);
        logic [PHASES-1:0] m;
        for (int i = 0; i < PHASES; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

    function automatic logic [NREG-1:0] reg_onehot(input int idx);
        logic [NREG-1:0] m;
        for (int i = 0; i < NREG; i++) begin
            m[i] = (i == idx);
        end
        return m;
    endfunction

    // Phase decode tables: one bit per phase, looked up with the next phase.
    localparam logic [PHASES-1:0] RD_PH_MASK = phase_mask(RT_PH, WT_PH);
    localparam logic [PHASES-1:0] CT_PH_MASK = phase_mask(CT_PH, CT_PH);
    localparam logic [PHASES-1:0] WT_PH_MASK = phase_mask(WT_PH, WT_PH);
    localparam logic [PHASES-1:0] LT_PH_MASK = phase_mask(PHASES - 1, PHASES - 1);
    localparam logic [NREG-1:0]   G_MASK     = reg_onehot(G_IDX);
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(PHASES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [NREG-1:0] rd_sel_q, rd_sel_d;
    logic [NREG-1:0] wr_sel_q, wr_sel_d;
    logic            ciff_q, ciff_d;

    logic [NREG-1:0] rdg_q, clrg_q, wrg_q;
    logic            ci01_q, busy_q, done_q;

    logic [NREG-1:0] addr_hot;
    logic [NREG-1:0] rd_new, wr_new;
    logic [31:0]     addr_ext;
    logic            accept;
    logic            run_d;

    // Decode the addressed register (codes >= NREG match no bit) and the new request sets.
    always_comb begin
        addr_ext = 32'(ADDR);
        addr_hot = '0;
        for (int i = 0; i < NREG; i++) begin
            addr_hot[i] = (addr_ext == 32'(i));
        end
        rd_new = RD_REQ | (ADDR_RD ? addr_hot : '0);
        wr_new = WR_REQ | (ADDR_WR ? addr_hot : '0);
        if (GINH) begin
            wr_new = wr_new & ~G_MASK;
        end
    end

    assign accept = TP_START && ((state_q == S_IDLE) || (ph_q == PH_LAST));

    // Next-state: accept a pulse from IDLE or on the last phase, otherwise step ph.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        rd_sel_d = rd_sel_q;
        wr_sel_d = wr_sel_q;
        ciff_d   = ciff_q;
        if (accept) begin
            state_d  = S_RUN;
            ph_d     = '0;
            rd_sel_d = rd_new;
            wr_sel_d = wr_new;
            ciff_d   = CI_REQ;
        end else if (state_q == S_RUN) begin
            if (ph_q == PH_LAST) begin
                state_d = S_IDLE;
                ph_d    = '0;
                ciff_d  = 1'b0;
            end else begin
                ph_d = ph_q + PH_W'(1);
            end
        end
        run_d = (state_d == S_RUN);
    end

    // State, latched sets and registered gate outputs decoded from the next state.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            rd_sel_q <= '0;
            wr_sel_q <= '0;
            ciff_q   <= 1'b0;
            rdg_q    <= '0;
            clrg_q   <= '0;
            wrg_q    <= '0;
            ci01_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            rd_sel_q <= rd_sel_d;
            wr_sel_q <= wr_sel_d;
            ciff_q   <= ciff_d;
            rdg_q    <= (run_d && RD_PH_MASK[ph_d]) ? rd_sel_d : '0;
            clrg_q   <= (run_d && CT_PH_MASK[ph_d]) ? wr_sel_d : '0;
            wrg_q    <= (run_d && WT_PH_MASK[ph_d]) ? wr_sel_d : '0;
            ci01_q   <= run_d && WT_PH_MASK[ph_d] && ciff_d;
            busy_q   <= run_d;
            done_q   <= run_d && LT_PH_MASK[ph_d];
        end
    end

`ifdef SVC_GATE_CONFLICT_EN
    logic rd_conf_q;

    // Sticky flag: more than one register selected onto the read bus at acceptance.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            rd_conf_q <= 1'b0;
        end else if (accept && (|(rd_new & (rd_new - NREG'(1))))) begin
            rd_conf_q <= 1'b1;
        end
    end

    assign RD_CONF = rd_conf_q;
`else
    assign RD_CONF = 1'b0;
`endif

    assign RDG  = rdg_q;
    assign CLRG = clrg_q;
    assign WRG  = wrg_q;
    assign CI01 = ci01_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_service_gate_sequencer.sv
// Bench for service_gate_sequencer: directed vector table, hand-written
// corner sequences, and random stimulus against a pulse-offset model.
// Two instances share inputs: defaults (NREG=8) and NREG=6.
module tb_service_gate_sequencer;

    localparam int PHASES = 4;
    localparam int RT_PH  = 1;
    localparam int CT_PH  = 2;
    localparam int WT_PH  = 3;
    localparam int G_IDX  = 5;
`ifdef SVC_GATE_CONFLICT_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       tp;
    logic [7:0] rd_req, wr_req;
    logic [2:0] addr;
    logic       addr_rd, addr_wr, ci_req, ginh;

    logic [7:0] rdg8, clrg8, wrg8;
    logic       ci8, busy8, done8, conf8;
    logic [5:0] rdg6, clrg6, wrg6;
    logic       ci6, busy6, done6, conf6;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    service_gate_sequencer u_dut (
        .SIM_CLK(clk), .SIM_RST_n(rst_n), .TP_START(tp),
        .RD_REQ(rd_req), .WR_REQ(wr_req), .ADDR(addr),
        .ADDR_RD(addr_rd), .ADDR_WR(addr_wr), .CI_REQ(ci_req), .GINH(ginh),
        .RDG(rdg8), .CLRG(clrg8), .WRG(wrg8), .CI01(ci8),
        .BUSY(busy8), .DONE(done8), .RD_CONF(conf8)
    );

    service_gate_sequencer #(.NREG(6)) u_dut6 (
        .SIM_CLK(clk), .SIM_RST_n(rst_n), .TP_START(tp),
        .RD_REQ(rd_req[5:0]), .WR_REQ(wr_req[5:0]), .ADDR(addr),
        .ADDR_RD(addr_rd), .ADDR_WR(addr_wr), .CI_REQ(ci_req), .GINH(ginh),
        .RDG(rdg6), .CLRG(clrg6), .WRG(wrg6), .CI01(ci6),
        .BUSY(busy6), .DONE(done6), .RD_CONF(conf6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_t = cycles elapsed since the current pulse was accepted, -1 when idle.
    int         m_t;
    logic [7:0] m_rd8, m_wr8, m_rd6, m_wr6;
    logic       m_ci, m_conf8, m_conf6;

    function automatic logic [7:0] pick(input logic [7:0] req, input logic en,
                                        input int a, input int nreg,
                                        input logic inh);
        logic [7:0] mask;
        logic [7:0] r;
        mask = 8'((1 << nreg) - 1);
        r = req & mask;
        if (en && a < nreg) r[a] = 1'b1;
        if (inh) r[G_IDX] = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= -1;
            m_rd8 <= '0; m_wr8 <= '0; m_rd6 <= '0; m_wr6 <= '0;
            m_ci <= 1'b0; m_conf8 <= 1'b0; m_conf6 <= 1'b0;
        end else if (tp && (m_t < 0 || m_t == PHASES - 1)) begin
            m_t   <= 0;
            m_rd8 <= pick(rd_req, addr_rd, int'(addr), 8, 1'b0);
            m_wr8 <= pick(wr_req, addr_wr, int'(addr), 8, ginh);
            m_rd6 <= pick(rd_req, addr_rd, int'(addr), 6, 1'b0);
            m_wr6 <= pick(wr_req, addr_wr, int'(addr), 6, ginh);
            m_ci  <= ci_req;
            if (CONF_EN && $countones(pick(rd_req, addr_rd, int'(addr), 8, 1'b0)) > 1)
                m_conf8 <= 1'b1;
            if (CONF_EN && $countones(pick(rd_req, addr_rd, int'(addr), 6, 1'b0)) > 1)
                m_conf6 <= 1'b1;
        end else if (m_t >= 0) begin
            m_t <= (m_t == PHASES - 1) ? -1 : m_t + 1;
        end
    end

    // Compare both instances with the model one time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            automatic bit in_rd = (m_t >= RT_PH) && (m_t <= WT_PH);
            automatic bit at_ct = (m_t == CT_PH);
            automatic bit at_wt = (m_t == WT_PH);
            chk("m8 RDG",  rdg8,  in_rd ? m_rd8 : 8'h00);
            chk("m8 CLRG", clrg8, at_ct ? m_wr8 : 8'h00);
            chk("m8 WRG",  wrg8,  at_wt ? m_wr8 : 8'h00);
            chk("m8 CI01", ci8,   at_wt && m_ci);
            chk("m8 BUSY", busy8, m_t >= 0);
            chk("m8 DONE", done8, m_t == PHASES - 1);
            chk("m8 CONF", conf8, m_conf8);
            chk("m6 RDG",  rdg6,  in_rd ? m_rd6 : 8'h00);
            chk("m6 CLRG", clrg6, at_ct ? m_wr6 : 8'h00);
            chk("m6 WRG",  wrg6,  at_wt ? m_wr6 : 8'h00);
            chk("m6 CI01", ci6,   at_wt && m_ci);
            chk("m6 BUSY", busy6, m_t >= 0);
            chk("m6 DONE", done6, m_t == PHASES - 1);
            chk("m6 CONF", conf6, m_conf6);
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        logic       tp;
        logic [7:0] rd, wr;
        logic [2:0] addr;
        logic       ard, awr, ci, inh;
        logic [7:0] e_rdg, e_clrg, e_wrg;
        logic       e_ci, e_busy, e_done;
    } vec_t;

    task automatic drive(input logic t, input logic [7:0] rd, input logic [7:0] wr,
                         input logic [2:0] a, input logic ard, input logic awr,
                         input logic ci, input logic inh);
        @(negedge clk);
        tp = t; rd_req = rd; wr_req = wr; addr = a;
        addr_rd = ard; addr_wr = awr; ci_req = ci; ginh = inh;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vt[10];

    initial begin
        rst_n = 1'b0;
        tp = 1'b0; rd_req = '0; wr_req = '0; addr = '0;
        addr_rd = 1'b0; addr_wr = 1'b0; ci_req = 1'b0; ginh = 1'b0;

        // idle rows default to zero inputs and zero outputs
        for (int i = 0; i < 10; i++) vt[i] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                                             8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        // pulse A: ADDR_RD addr 2, WR_REQ 01
        vt[0] = '{1'b1, 8'h00, 8'h01, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[1].e_rdg = 8'h04; vt[1].e_busy = 1'b1;
        vt[2].e_rdg = 8'h04; vt[2].e_clrg = 8'h01; vt[2].e_busy = 1'b1;
        vt[3].e_rdg = 8'h04; vt[3].e_wrg = 8'h01; vt[3].e_busy = 1'b1; vt[3].e_done = 1'b1;
        // pulse B: WR_REQ 20 with GINH, CI_REQ
        vt[5] = '{1'b1, 8'h00, 8'h20, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[6].e_busy = 1'b1;
        vt[7].e_busy = 1'b1;
        vt[8].e_busy = 1'b1; vt[8].e_ci = 1'b1; vt[8].e_done = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst RDG", rdg8, 8'h00);
        chk("rst WRG", wrg8, 8'h00);
        chk("rst CLRG", clrg8, 8'h00);
        chk("rst BUSY", {busy8, done8, ci8, conf8}, 4'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].tp, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].ard, vt[i].awr, vt[i].ci, vt[i].inh);
            chk($sformatf("vec%0d RDG", i),  rdg8,  vt[i].e_rdg);
            chk($sformatf("vec%0d CLRG", i), clrg8, vt[i].e_clrg);
            chk($sformatf("vec%0d WRG", i),  wrg8,  vt[i].e_wrg);
            chk($sformatf("vec%0d CI01", i), ci8,   vt[i].e_ci);
            chk($sformatf("vec%0d BUSY", i), busy8, vt[i].e_busy);
            chk($sformatf("vec%0d DONE", i), done8, vt[i].e_done);
            chk($sformatf("vec%0d CONF", i), conf8, 1'b0);
        end

        // ADDR=7 on the NREG=6 instance selects nothing
        drive(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < PHASES; p++) begin
            chk("a7 n6 gates", {rdg6, clrg6, wrg6}, 18'h0);
            if (p == WT_PH) chk("a7 n8 WRG", wrg8, 8'h80);
            if (p < PHASES - 1) idle_step();
        end
        idle_step();

        // read conflict, then three clean pulses
        drive(1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("conf at accept", conf8, CONF_EN);
        idle_step();
        chk("conf RDG", rdg8, 8'h03);
        idle_step(); idle_step(); idle_step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h01, 8'h02, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            repeat (PHASES) idle_step();
        end
        chk("conf sticky", conf8, CONF_EN);

        // back-to-back pulses; later requests in RUN ignored until DONE edge
        drive(1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b busy ph0", {busy8, done8}, 2'b10);
        drive(1'b1, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b rdg ph1", rdg8, 8'h01);
        drive(1'b1, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b done1", {busy8, done8}, 2'b11);
        drive(1'b1, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b busy p2", {busy8, done8}, 2'b10);
        idle_step();
        chk("b2b rdg p2", rdg8, 8'h10);
        drive(1'b1, 8'h40, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b ignore rdg", rdg8, 8'h10);
        idle_step();
        chk("b2b done2", {busy8, done8}, 2'b11);
        idle_step();
        chk("b2b end idle", busy8, 1'b0);

        // asynchronous reset while CLRG is active
        drive(1'b1, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_step(); idle_step();
        chk("pre-rst CLRG", clrg8, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst gates", {rdg8, clrg8, wrg8}, 24'h0);
        chk("async rst flags", {ci8, busy8, done8, conf8}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_step(); idle_step(); idle_step();
        chk("post-rst WRG", wrg8, 8'h01);
        chk("post-rst CI01", ci8, 1'b0);
        idle_step();

        // random stimulus, checked by the model monitor
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 99) < 40, 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (PHASES + 1) idle_step();
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
